mult32x32_ctrl: RTL and testbench
=================================

// Module: mult32x32_ctrl
// PURPOSE
//  Sequencing controller for the 32x32 multiplier arithmetic unit (16x8 partial-product datapath).
//  Accepts a start request and drives a_sel/b_sel/shift_sel/upd_prod/clr_prod.
//  Accumulates the 8 partial products a_byte[i]*b_half[j] << (8*i+16*j) into the datapath product register.
//  Reports busy/done to the requesting logic; optionally skips partial products with a zero operand slice.
// PARAMETERS
//  SKIP_ZERO  0  1: skip steps whose a byte or b half-word is zero; 0: always run all 8 steps
// PORTS
//  clk        in   1   clock; all state updates on posedge
//  reset      in   1   synchronous, active-high reset
//  start      in   1   request a multiplication; sampled in IDLE only
//  a          in   32  operand A (used only for SKIP_ZERO decisions); held stable start..done
//  b          in   32  operand B (used only for SKIP_ZERO decisions); held stable start..done
//  a_sel      out  2   byte select of A to datapath
//  b_sel      out  1   half-word select of B to datapath
//  shift_sel  out  3   partial-product shift select (k -> shift 8*k)
//  upd_prod   out  1   accumulate into product register this cycle
//  clr_prod   out  1   clear product register this cycle
//  busy       out  1   high while a multiplication is in progress (STEP or FIN)
//  done       out  1   one-cycle pulse; product register holds final result this cycle
// BEHAVIOUR
//  - States:
//    - IDLE
//    - STEP(k), k=0..7 with (b_sel,a_sel) = {k[2],k[1:0]}
//    - FIN
//  - Step order 0..7:
//    - (b0,a0),(b0,a1),(b0,a2),(b0,a3),(b1,a0),(b1,a1),(b1,a2),(b1,a3)
//    - shift_sel = a_sel + 2*b_sel; values 0..5 only, never 6/7
//  - Outputs in IDLE/FIN: a_sel=0, b_sel=0, shift_sel=0, upd_prod=0.
//  - IDLE:
//    - clr_prod = start (Mealy); the same edge loads the first step (STEP0, or first non-skipped step).
//    - If SKIP_ZERO=1 and every step is skipped (a==0 or b==0) -> go to FIN.
//  - STEP(k):
//    - upd_prod=1, clr_prod=0, selects per k, busy=1.
//    - Next state = next non-skipped step after k, else FIN.
//  - FIN: done=1, busy=1 for exactly one cycle -> IDLE.
//  - Skip rule (SKIP_ZERO=1 only): step k skipped iff a[8*k[1:0]+:8]==0 or b[16*k[2]+:16]==0.
//  - Latency (start edge at cycle T):
//    - SKIP_ZERO=0: 8 upd cycles T+1..T+8; done at T+9; next start accepted T+10.
//    - SKIP_ZERO=1: done at T+1+N, N = number of non-skipped steps (0..8).
//  - start while busy (STEP/FIN) is ignored; no queueing.
//  - reset:
//    - High: next state IDLE; all outputs 0 during the reset cycle, including clr_prod even if start=1.
//    - Mid-operation: abort, no done pulse, product contents left to datapath reset.
//  - Reset values: a_sel=0, b_sel=0, shift_sel=0, upd_prod=0, clr_prod=0, busy=0, done=0.
//  - upd_prod and clr_prod are never high in the same cycle.
// TESTING
//  - SKIP_ZERO=0, a=b=0xFFFFFFFF, start 1 cycle:
//    - clr_prod@T, upd_prod T+1..T+8 with shift_sel 0,1,2,3,2,3,4,5
//    - done@T+9, datapath product=0xFFFFFFFE00000001
//  - SKIP_ZERO=0, a=0x00000002, b=0x00000003:
//    - still 8 upd cycles, done@T+9, product=0x6
//  - SKIP_ZERO=1, a=0x00010000, b=0x00000003:
//    - single STEP (a_sel=2, b_sel=0, shift_sel=2), done@T+2, product=0x30000
//  - SKIP_ZERO=1, a=0, b=0x1234:
//    - clr_prod@T, no upd_prod, done@T+1, product=0
//  - start pulses at T+3 and T+9 during a run:
//    - ignored, single done@T+9
//    - start at T+10 begins a new run (clr_prod@T+10)
//  - reset asserted at T+4 mid-run:
//    - IDLE at T+5, all outputs 0, no done pulse
//    - subsequent start runs a full 8 steps normally

Source files
------------

// File: rtl/mult32x32_ctrl_if.sv
// Handshake and control bundle between the requester/datapath and the 32x32 multiplier sequencer.
interface mult32x32_ctrl_if;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic [1:0]  a_sel;
  logic        b_sel;
  logic [2:0]  shift_sel;
  logic        upd_prod;
  logic        clr_prod;
  logic        busy;
  logic        done;

  modport master (
    output start, a, b,
    input  a_sel, b_sel, shift_sel, upd_prod, clr_prod, busy, done
  );

  modport slave (
    input  start, a, b,
    output a_sel, b_sel, shift_sel, upd_prod, clr_prod, busy, done
  );
endinterface

// File: rtl/mult32x32_ctrl.sv
// Sequencer for the 16x8 partial-product datapath: walks the 8 (b half, a byte) steps,
// optionally skipping steps whose operand slice is zero, then pulses done.
//
// state | meaning
// IDLE  | waiting for start; clr_prod follows start and the first step is loaded
// STEP  | accumulate partial product k (b_sel=k[2], a_sel=k[1:0])
// FIN   | product register final; done pulse, one cycle
module mult32x32_ctrl #(
  parameter bit SKIP_ZERO = 1'b0
) (
  input logic             clk,
  input logic             reset,
  mult32x32_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, STEP, FIN} state_t;

  state_t     state, state_next;
  logic [2:0] k, k_next;
  logic [7:0] active;
  logic [3:0] from;
  logic       found;
  logic [2:0] first;

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      if (SKIP_ZERO)
        active[i] = (bus.a[8*(i%4) +: 8] != 8'd0) && (bus.b[16*(i/4) +: 16] != 16'd0);
      else
        active[i] = 1'b1;
    end
  end

  // Lowest active step at or after 'from'; from=8 after the last step finds nothing.
  assign from = (state == STEP) ? ({1'b0, k} + 4'd1) : 4'd0;

  always_comb begin
    found = 1'b0;
    first = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (active[i] && (4'(i) >= from)) begin
        found = 1'b1;
        first = 3'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      k     <= 3'd0;
    end else begin
      state <= state_next;
      k     <= k_next;
    end
  end

  always_comb begin
    state_next    = state;
    k_next        = k;
    bus.a_sel     = 2'd0;
    bus.b_sel     = 1'b0;
    bus.shift_sel = 3'd0;
    bus.upd_prod  = 1'b0;
    bus.clr_prod  = 1'b0;
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          bus.clr_prod = 1'b1;
          if (found) begin
            state_next = STEP;
            k_next     = first;
          end else begin
            state_next = FIN;
          end
        end
      end
      STEP: begin
        bus.upd_prod  = 1'b1;
        bus.busy      = 1'b1;
        bus.a_sel     = k[1:0];
        bus.b_sel     = k[2];
        bus.shift_sel = {1'b0, k[1:0]} + {1'b0, k[2], 1'b0};
        if (found) k_next = first;
        else       state_next = FIN;
      end
      FIN: begin
        bus.done   = 1'b1;
        bus.busy   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Reset cycle forces every output low, including the Mealy clr_prod.
    if (reset) begin
      bus.a_sel     = 2'd0;
      bus.b_sel     = 1'b0;
      bus.shift_sel = 3'd0;
      bus.upd_prod  = 1'b0;
      bus.clr_prod  = 1'b0;
      bus.busy      = 1'b0;
      bus.done      = 1'b0;
    end
  end

endmodule

// File: tb/tb_mult32x32_ctrl.sv
// Bench for mult32x32_ctrl: one instance per SKIP_ZERO setting, a product-register model
// fed by the control outputs, and a per-cycle expected trace built from the step rules.
module tb_mult32x32_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mult32x32_ctrl_if bus0();
  mult32x32_ctrl_if bus1();

  mult32x32_ctrl #(.SKIP_ZERO(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  mult32x32_ctrl #(.SKIP_ZERO(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  logic        start_v [2];
  logic [31:0] a_v [2];
  logic [31:0] b_v [2];
  logic [9:0]  obs [2];
  logic [63:0] prod [2];

  assign bus0.start = start_v[0];
  assign bus0.a     = a_v[0];
  assign bus0.b     = b_v[0];
  assign bus1.start = start_v[1];
  assign bus1.a     = a_v[1];
  assign bus1.b     = b_v[1];

  // {a_sel, b_sel, shift_sel, upd, clr, busy, done}
  assign obs[0] = {bus0.a_sel, bus0.b_sel, bus0.shift_sel, bus0.upd_prod, bus0.clr_prod, bus0.busy, bus0.done};
  assign obs[1] = {bus1.a_sel, bus1.b_sel, bus1.shift_sel, bus1.upd_prod, bus1.clr_prod, bus1.busy, bus1.done};

  int n_cmp = 0;
  int n_err = 0;
  logic [9:0] exp_q [$];

  function automatic logic [9:0] mk(int asel, int bsel, int sh, int upd, int clr, int busy, int done);
    return {2'(asel), 1'(bsel), 3'(sh), 1'(upd), 1'(clr), 1'(busy), 1'(done)};
  endfunction

  function automatic logic [63:0] pp(logic [31:0] a, logic [31:0] b, logic [1:0] asel,
                                     logic bsel, logic [2:0] sh);
    logic [63:0] ab, bh;
    ab = {32'd0, a >> (8 * int'(asel))} & 64'hFF;
    bh = {32'd0, b >> (16 * int'(bsel))} & 64'hFFFF;
    return (ab * bh) << (8 * int'(sh));
  endfunction

  // Datapath product register driven only by the controller outputs.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (obs[i][2])      prod[i] <= 64'd0;
      else if (obs[i][3]) prod[i] <= prod[i] + pp(a_v[i], b_v[i], obs[i][9:8], obs[i][7], obs[i][6:4]);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Expected outputs for cycles T+1..done from the step/skip rules.
  task automatic build_trace(input logic [31:0] a, input logic [31:0] b, input bit skip);
    int ab, bh;
    exp_q.delete();
    for (int k = 0; k < 8; k++) begin
      ab = int'((a >> (8 * (k % 4))) & 32'hFF);
      bh = int'((b >> (16 * (k / 4))) & 32'hFFFF);
      if (!skip || (ab != 0 && bh != 0))
        exp_q.push_back(mk(k % 4, k / 4, k % 4 + 2 * (k / 4), 1, 0, 1, 0));
    end
    exp_q.push_back(mk(0, 0, 0, 0, 0, 1, 1));
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after done.
  task automatic run_op(input int d, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [63:0] p);
    int n;
    lat = -1;
    p   = 64'd0;
    a_v[d] = a; b_v[d] = b; start_v[d] = 1'b1;
    @(negedge clk); #1;
    chk("start_cycle", {54'd0, obs[d]}, {54'd0, mk(0, 0, 0, 0, 1, 0, 0)});
    build_trace(a, b, d == 1);
    n = exp_q.size();
    for (int c = 1; c <= n; c++) begin
      @(posedge clk); #1;
      start_v[d] = 1'b0;
      @(negedge clk); #1;
      chk($sformatf("trace_c%0d", c), {54'd0, obs[d]}, {54'd0, exp_q[c-1]});
      if (obs[d][0] && lat < 0) begin
        lat = c;
        p   = prod[d];
      end
    end
    @(posedge clk); #1;
    start_v[d] = 1'b0;
  endtask

  typedef struct {
    int          d;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] prod;
    int          lat;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int          lat, nact, extra;
    logic [63:0] p;
    logic [31:0] ra, rb;
    int          dd;

    vecs[0] = '{0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 9};
    vecs[1] = '{0, 32'h0000_0002, 32'h0000_0003, 64'h6, 9};
    vecs[2] = '{1, 32'h0001_0000, 32'h0000_0003, 64'h3_0000, 2};
    vecs[3] = '{1, 32'h0000_0000, 32'h0000_1234, 64'h0, 1};

    // Reset with start asserted: clr_prod must stay low.
    reset = 1'b1;
    start_v[0] = 1'b1; a_v[0] = 32'hFFFF_FFFF; b_v[0] = 32'hFFFF_FFFF;
    start_v[1] = 1'b0; a_v[1] = 32'd0;         b_v[1] = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("reset_out0", {54'd0, obs[0]}, 64'd0);
    chk("reset_out1", {54'd0, obs[1]}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    start_v[0] = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++) begin
      run_op(vecs[i].d, vecs[i].a, vecs[i].b, lat, p);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
      chk($sformatf("vec%0d_product", i), p, vecs[i].prod);
    end

    // Start pulses at T+3 and T+9 are ignored; start at T+10 opens a new run.
    a_v[0] = 32'hFFFF_FFFF; b_v[0] = 32'hFFFF_FFFF; start_v[0] = 1'b1;
    @(negedge clk); #1;
    chk("ign_start", {54'd0, obs[0]}, {54'd0, mk(0, 0, 0, 0, 1, 0, 0)});
    build_trace(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    for (int c = 1; c <= 9; c++) begin
      @(posedge clk); #1;
      start_v[0] = (c == 3 || c == 9);
      @(negedge clk); #1;
      chk($sformatf("ign_c%0d", c), {54'd0, obs[0]}, {54'd0, exp_q[c-1]});
    end
    chk("ign_product", prod[0], 64'hFFFF_FFFE_0000_0001);
    @(posedge clk); #1;
    run_op(0, 32'h2, 32'h3, lat, p);
    chk("ign_next_latency", 64'(lat), 64'd9);
    chk("ign_next_product", p, 64'h6);

    // Reset mid-run at T+4: outputs zero immediately, idle afterwards, no done.
    a_v[0] = 32'hFFFF_FFFF; b_v[0] = 32'hFFFF_FFFF; start_v[0] = 1'b1;
    @(negedge clk); #1;
    chk("abort_start", {54'd0, obs[0]}, {54'd0, mk(0, 0, 0, 0, 1, 0, 0)});
    build_trace(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      start_v[0] = 1'b0;
      @(negedge clk); #1;
      chk($sformatf("abort_c%0d", c), {54'd0, obs[0]}, {54'd0, exp_q[c-1]});
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk); #1;
    chk("abort_reset_cycle", {54'd0, obs[0]}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    extra = 0;
    for (int c = 5; c <= 14; c++) begin
      @(negedge clk); #1;
      if (obs[0] != 10'd0) extra++;
      @(posedge clk); #1;
    end
    chk("abort_idle_cycles", 64'(extra), 64'd0);
    run_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, p);
    chk("abort_rerun_latency", 64'(lat), 64'd9);
    chk("abort_rerun_product", p, 64'hFFFF_FFFE_0000_0001);

    // Randomized operands with frequent zero slices to exercise skipping.
    for (int r = 0; r < 60; r++) begin
      dd = int'($urandom_range(0, 1));
      ra = $urandom;
      rb = $urandom;
      for (int j = 0; j < 4; j++) if ($urandom_range(0, 2) == 0) ra[8*j +: 8] = 8'd0;
      for (int j = 0; j < 2; j++) if ($urandom_range(0, 3) == 0) rb[16*j +: 16] = 16'd0;
      nact = 0;
      for (int k = 0; k < 8; k++)
        if (dd == 0 || (ra[8*(k%4) +: 8] != 8'd0 && rb[16*(k/4) +: 16] != 16'd0)) nact++;
      run_op(dd, ra, rb, lat, p);
      chk($sformatf("rnd%0d_latency", r), 64'(lat), 64'(nact + 1));
      chk($sformatf("rnd%0d_product", r), p, {32'd0, ra} * {32'd0, rb});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
